mem_arbiter_sv: RTL and testbench
=================================

# mem_arbiter_sv

Arbiter that shares one single-port, fixed-latency memory between the CPU's instruction-fetch (IF) port and data-access (MEM) port. It sits between the 5-stage pipeline (`main_sv`) and the unified RAM. It grants one transaction at a time and tracks its fixed read latency. It favours the MEM stage, with a starvation guard for IF so neither port can be locked out.

## Interface

**Parameters**
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: RAM read latency in cycles, from `ram_en` to `ram_rdata` valid. Legal range 1..8.
- `STARVE_MAX`, 4: number of consecutive MEM wins over a pending IF request before IF is forced.

**Ports**
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: IF read request; held until `if_gnt`.
- `if_addr` in ADDR_W: IF read address.
- `if_gnt` out 1: one-cycle pulse; IF request accepted.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out DATA_W: fetched word.
- `mem_req` in 1: MEM request; held until `mem_gnt`.
- `mem_we` in 1: 1 = write, 0 = read.
- `mem_addr` in ADDR_W: MEM address.
- `mem_wdata` in DATA_W: MEM write data.
- `mem_gnt` out 1: one-cycle pulse; MEM request accepted.
- `mem_rvalid` out 1: one-cycle pulse; read data valid or write acknowledged.
- `mem_rdata` out DATA_W: read data; 0 for write acks.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data.
- `busy` out 1: a transaction is outstanding (granted, `rvalid` not yet issued).

## Operation

- **States.**
  - IDLE: no transaction outstanding.
  - WAIT: a transaction is outstanding. The block tracks `owner` (IF/MEM), `is_write` and `lat_cnt`.
- **Grant eligibility.** A grant may be issued when the state is IDLE, or in WAIT during the cycle in which `lat_cnt` expires (that cycle also issues `rvalid`).
- **Grant path.** The grant is combinational from the request inputs:
  - `*_gnt`, `ram_en`, `ram_we`, `ram_addr` and `ram_wdata` are driven in the same cycle.
  - `ram_we` = `mem_we` for a MEM grant and 0 for an IF grant.
- **Priority.**
  - Only one request pending: that port wins.
  - Both pending: MEM wins, unless `starve_cnt == STARVE_MAX`, in which case IF wins.
- **`starve_cnt`.**
  - Increments, saturating at STARVE_MAX, on every MEM grant issued while `if_req` = 1.
  - Clears to 0 on every IF grant.
  - Otherwise it holds.
- **On grant.**
  - State goes to WAIT.
  - `lat_cnt` loads MEM_LAT and decrements each cycle.
  - In the cycle where `lat_cnt == 1`, the owner's `rvalid` pulses and `rdata` is driven combinationally from `ram_rdata`. The next state is IDLE unless a new grant is issued in that same cycle.
- **Writes.**
  - A write holds the same latency.
  - `mem_rvalid` pulses at grant + MEM_LAT with `mem_rdata` = 0.
- **Inactive outputs.** When `rvalid` is low, `if_rdata` and `mem_rdata` are 0.
- **Request discipline.** A requester deasserting `req` before its grant is legal; no grant is issued for it.
- **Out-of-range requests.** A request arriving while WAIT is not expiring is not granted; the requester keeps waiting.

## Timing

- **Reset values.**
  - All outputs are 0.
  - State = IDLE, `starve_cnt` = 0, `lat_cnt` = 0, `owner` = IF.
- **Latency.** Grant at cycle N gives `rvalid` at cycle N+MEM_LAT.
- **Throughput.** Back-to-back grants every MEM_LAT cycles (the grant overlaps the previous `rvalid` cycle).
- **`busy`.** High from the cycle after a grant through the `rvalid` cycle. It stays high continuously when a new grant occurs in the `rvalid` cycle.
- **Exclusivity.** `if_gnt` and `mem_gnt` are never high together, and `if_rvalid` and `mem_rvalid` are never high together.
- **Reset mid-transaction.** The block returns to IDLE immediately. No `rvalid` is issued for the aborted access, and `starve_cnt` is cleared.
- **Reset release.** A request present in the first cycle after reset deasserts is grantable in that cycle.
- **MEM_LAT = 1.** `rvalid` occurs in the cycle after the grant, and a new grant can be issued every cycle.

## Test plan

All scenarios use MEM_LAT=2 and STARVE_MAX=4 unless noted.

1. **Single IF read.** `if_req` at cycle 3 with `if_addr`=0x10 and `ram_rdata`=0xDEADBEEF at cycle 5 → `if_gnt` and `ram_en` at 3 with `ram_addr`=0x10; `if_rvalid` at 5 with `if_rdata`=0xDEADBEEF; `busy` high in cycles 4-5.
2. **Contention.** `if_req` and `mem_req` (read, 0x20) both high at cycle 3 → `mem_gnt` at 3, `if_gnt` at 5, `if_rvalid` at 7; `starve_cnt` = 1 then 0.
3. **Starvation guard.** `if_req` and `mem_req` held high continuously → MEM is granted 4 times (cycles 0, 2, 4, 6), then IF at cycle 8, then MEM at cycle 10.
4. **Write ack.** `mem_req`=1, `mem_we`=1, `mem_addr`=0x40, `mem_wdata`=0x1234 → `ram_we`=1 with that address and data in the grant cycle; `mem_rvalid` 2 cycles later with `mem_rdata`=0; no `if_rvalid`.
5. **Reset mid-transaction.** Assert `reset` one cycle after an IF grant → no `if_rvalid`; all outputs 0 during reset; after release, a new `if_req` is granted in its first cycle.
6. **MEM_LAT=1 streaming.** `if_req` held high for 4 cycles → `if_gnt` every cycle, `if_rvalid` every cycle starting one cycle later, `busy` continuous.

Source files
------------

// File: rtl/mem_arbiter_sv.sv
// mem_arbiter_sv: shares one fixed-latency single-port RAM between IF and MEM.
// MEM has priority; IF is forced after STARVE_MAX consecutive losses.
module mem_arbiter_sv #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          r_state;
  logic            r_owner_mem;
  logic            r_is_write;
  logic [3:0]      r_lat_cnt;
  logic [SW-1:0]   r_starve_cnt;

  logic w_expire;
  logic w_elig;
  logic w_starved;
  logic w_mem_win;
  logic w_if_win;
  logic w_grant;
  logic w_rv;

  // Grant eligibility and priority; reset masks every grant.
  always_comb begin
    w_expire  = (r_state == ST_WAIT) && (r_lat_cnt == 4'd1);
    w_elig    = !reset && ((r_state == ST_IDLE) || w_expire);
    w_starved = (r_starve_cnt == SMAX);
    w_mem_win = w_elig && mem_req && !(if_req && w_starved);
    w_if_win  = w_elig && if_req && !w_mem_win;
    w_grant   = w_mem_win || w_if_win;
    w_rv      = w_expire && !reset;
  end

  // RAM request side is driven in the grant cycle.
  always_comb begin
    if_gnt    = w_if_win;
    mem_gnt   = w_mem_win;
    ram_en    = w_grant;
    ram_we    = w_mem_win && mem_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_mem_win) begin
      ram_addr = mem_addr;
      if (mem_we) ram_wdata = mem_wdata;
    end else if (w_if_win) begin
      ram_addr = if_addr;
    end
  end

  // Response side: owner's rvalid and data when the latency expires.
  always_comb begin
    if_rvalid  = w_rv && !r_owner_mem;
    mem_rvalid = w_rv && r_owner_mem;
    if_rdata   = '0;
    mem_rdata  = '0;
    if (if_rvalid) if_rdata = ram_rdata;
    if (mem_rvalid && !r_is_write) mem_rdata = ram_rdata;
    busy = (r_state == ST_WAIT);
  end

  // Transaction FSM: owner, direction and latency countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner_mem <= 1'b0;
      r_is_write  <= 1'b0;
      r_lat_cnt   <= 4'd0;
    end else if (w_grant) begin
      r_state     <= ST_WAIT;
      r_owner_mem <= w_mem_win;
      r_is_write  <= w_mem_win && mem_we;
      r_lat_cnt   <= LAT;
    end else if (r_state == ST_WAIT) begin
      r_lat_cnt <= r_lat_cnt - 4'd1;
      if (w_expire) r_state <= ST_IDLE;
    end
  end

  // Starvation counter: MEM wins over a waiting IF, cleared by IF grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_if_win) begin
      r_starve_cnt <= '0;
    end else if (w_mem_win && if_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_sv.sv
// tb_mem_arbiter_sv: directed scenarios with a scoreboard of expected
// grants, responses and level checks, drained by a negedge monitor.
module tb_mem_arbiter_sv;

  typedef struct {
    int          c;
    bit          m;
    logic [31:0] a;
    bit          we;
    logic [31:0] d;
  } ev_t;

  typedef struct {
    int c;
    bit zero;
    bit v;
  } lv_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] ram_rdata;
  logic        fix_en;
  logic [31:0] fix_val;
  logic        sel;
  logic        done;
  int          cyc;
  int          base;

  ev_t gq[$];
  ev_t rq[$];
  lv_t lq[$];

  int n_vec = 0;
  int n_err = 0;

  logic        a_ig, a_irv, a_mg, a_mrv, a_en, a_we, a_busy;
  logic [31:0] a_ird, a_mrd, a_addr, a_wd;
  logic        b_ig, b_irv, b_mg, b_mrv, b_en, b_we, b_busy;
  logic [31:0] b_ird, b_mrd, b_addr, b_wd;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ram_rdata = fix_en ? fix_val : {16'hC0DE, cyc[15:0]};

  mem_arbiter_sv #(.MEM_LAT(2), .STARVE_MAX(4)) u0 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(a_ig), .if_rvalid(a_irv), .if_rdata(a_ird),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt(a_mg), .mem_rvalid(a_mrv), .mem_rdata(a_mrd),
    .ram_en(a_en), .ram_we(a_we), .ram_addr(a_addr),
    .ram_wdata(a_wd), .ram_rdata(ram_rdata), .busy(a_busy)
  );

  mem_arbiter_sv #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(b_ig), .if_rvalid(b_irv), .if_rdata(b_ird),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt(b_mg), .mem_rvalid(b_mrv), .mem_rdata(b_mrd),
    .ram_en(b_en), .ram_we(b_we), .ram_addr(b_addr),
    .ram_wdata(b_wd), .ram_rdata(ram_rdata), .busy(b_busy)
  );

  logic        m_ig, m_irv, m_mg, m_mrv, m_en, m_we, m_busy, m_any;
  logic [31:0] m_ird, m_mrd, m_addr, m_wd;

  assign m_ig   = sel ? b_ig   : a_ig;
  assign m_irv  = sel ? b_irv  : a_irv;
  assign m_mg   = sel ? b_mg   : a_mg;
  assign m_mrv  = sel ? b_mrv  : a_mrv;
  assign m_en   = sel ? b_en   : a_en;
  assign m_we   = sel ? b_we   : a_we;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_ird  = sel ? b_ird  : a_ird;
  assign m_mrd  = sel ? b_mrd  : a_mrd;
  assign m_addr = sel ? b_addr : a_addr;
  assign m_wd   = sel ? b_wd   : a_wd;
  assign m_any  = |{m_ig, m_irv, m_mg, m_mrv, m_en, m_we, m_busy,
                    m_ird, m_mrd, m_addr, m_wd};

  // Monitor: drains the scoreboard queues against DUT activity.
  always @(negedge clk) begin
    ev_t e;
    lv_t l;
    bit ok;
    logic [31:0] rd;
    if (!done) begin
      while (lq.size() > 0 && lq[0].c <= cyc) begin
        l = lq.pop_front();
        n_vec++;
        if (l.c != cyc) begin
          n_err++;
          $display("FAIL lvl_missed: checked @%0d, wanted @%0d", cyc, l.c);
        end else if (l.zero) begin
          if (m_any !== 1'b0) begin
            n_err++;
            $display("FAIL rst_zero @%0d: got outputs active, want all 0",
                     cyc);
          end
        end else if (m_busy !== l.v) begin
          n_err++;
          $display("FAIL busy @%0d: got %b, want %b", cyc, m_busy, l.v);
        end
      end
      while (gq.size() > 0 && gq[0].c < cyc) begin
        e = gq.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL gnt_missing: none @%0d, want mem=%0b addr=%h",
                 e.c, e.m, e.a);
      end
      if (m_ig || m_mg) begin
        n_vec++;
        if (gq.size() == 0) begin
          n_err++;
          $display("FAIL gnt_extra @%0d: got if=%b mem=%b, want none",
                   cyc, m_ig, m_mg);
        end else begin
          e = gq.pop_front();
          ok = (e.c == cyc) && !(m_ig && m_mg) && (m_mg == e.m) &&
               (m_en === 1'b1) && (m_addr === e.a) &&
               (m_we === e.we) && (!e.we || m_wd === e.d);
          if (!ok) begin
            n_err++;
            $display({"FAIL gnt @%0d: got if=%b mem=%b en=%b addr=%h ",
                      "we=%b wd=%h, want @%0d mem=%0b addr=%h we=%0b wd=%h"},
                     cyc, m_ig, m_mg, m_en, m_addr, m_we, m_wd,
                     e.c, e.m, e.a, e.we, e.d);
          end
        end
      end
      while (rq.size() > 0 && rq[0].c < cyc) begin
        e = rq.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL rv_missing: none @%0d, want mem=%0b data=%h",
                 e.c, e.m, e.d);
      end
      if (m_irv || m_mrv) begin
        n_vec++;
        rd = m_mrv ? m_mrd : m_ird;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL rv_extra @%0d: got if=%b mem=%b, want none",
                   cyc, m_irv, m_mrv);
        end else begin
          e = rq.pop_front();
          ok = (e.c == cyc) && !(m_irv && m_mrv) && (m_mrv == e.m) &&
               (rd === e.d) &&
               ((m_mrv ? m_ird : m_mrd) === 32'h0);
          if (!ok) begin
            n_err++;
            $display({"FAIL rv @%0d: got if=%b mem=%b ird=%h mrd=%h, ",
                      "want @%0d mem=%0b data=%h"},
                     cyc, m_irv, m_mrv, m_ird, m_mrd, e.c, e.m, e.d);
          end
        end
      end
    end else begin
      n_vec++;
      if (gq.size() + rq.size() + lq.size() != 0) begin
        n_err++;
        $display("FAIL leftover: got %0d/%0d/%0d pending, want 0/0/0",
                 gq.size(), rq.size(), lq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < base + c) step();
  endtask

  task automatic xg(input int c, input bit m, input logic [31:0] a,
                    input bit we, input logic [31:0] d);
    gq.push_back('{base + c, m, a, we, d});
  endtask

  task automatic xr(input int c, input bit m, input logic [31:0] d);
    rq.push_back('{base + c, m, 32'h0, 1'b0, d});
  endtask

  task automatic xl(input int c, input bit zero, input bit v);
    lq.push_back('{base + c, zero, v});
  endtask

  function automatic logic [31:0] pat(input int c);
    int t;
    t = base + c;
    return {16'hC0DE, t[15:0]};
  endfunction

  initial begin
    reset = 1'b1;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    fix_en = 1'b0; fix_val = '0; sel = 1'b0; done = 1'b0;
    base = 0;

    // reset state, with requests present
    step();
    base = cyc;
    if_req = 1'b1; mem_req = 1'b1; mem_addr = 32'h8;
    xl(0, 1'b1, 1'b0);
    xl(1, 1'b1, 1'b0);
    go(2);
    reset = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    step();

    // 1: single IF read
    base = cyc;
    fix_en = 1'b1; fix_val = 32'hDEADBEEF;
    xg(3, 1'b0, 32'h10, 1'b0, 32'h0);
    xr(5, 1'b0, 32'hDEADBEEF);
    xl(3, 1'b0, 1'b0); xl(4, 1'b0, 1'b1);
    xl(5, 1'b0, 1'b1); xl(6, 1'b0, 1'b0);
    go(3); if_req = 1'b1; if_addr = 32'h10;
    go(4); if_req = 1'b0;
    go(7); fix_en = 1'b0;

    // 2: contention, MEM first
    base = cyc;
    xg(3, 1'b1, 32'h20, 1'b0, 32'h0);
    xg(5, 1'b0, 32'h24, 1'b0, 32'h0);
    xr(5, 1'b1, pat(5));
    xr(7, 1'b0, pat(7));
    go(3);
    if_req = 1'b1; if_addr = 32'h24;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h20;
    go(4); mem_req = 1'b0;
    go(6); if_req = 1'b0;
    go(8);

    // 3: starvation guard with both requests held
    base = cyc;
    for (int k = 0; k < 4; k++) begin
      xg(2 * k, 1'b1, 32'h100, 1'b0, 32'h0);
      xr(2 * k + 2, 1'b1, pat(2 * k + 2));
    end
    xg(8, 1'b0, 32'h200, 1'b0, 32'h0);
    xr(10, 1'b0, pat(10));
    xg(10, 1'b1, 32'h100, 1'b0, 32'h0);
    xr(12, 1'b1, pat(12));
    for (int k = 1; k <= 12; k++) xl(k, 1'b0, 1'b1);
    xl(13, 1'b0, 1'b0);
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    go(11); if_req = 1'b0; mem_req = 1'b0;
    go(14);

    // 4: write acknowledge
    base = cyc;
    xg(1, 1'b1, 32'h40, 1'b1, 32'h1234);
    xr(3, 1'b1, 32'h0);
    xl(3, 1'b0, 1'b1); xl(4, 1'b0, 1'b0);
    go(1);
    mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 32'h40; mem_wdata = 32'h1234;
    go(2); mem_req = 1'b0; mem_we = 1'b0;
    go(5);

    // late request withdrawn before eligibility
    base = cyc;
    xg(1, 1'b1, 32'h70, 1'b0, 32'h0);
    xr(3, 1'b1, pat(3));
    xl(4, 1'b0, 1'b0);
    go(1); mem_req = 1'b1; mem_addr = 32'h70;
    go(2); mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h74;
    go(3); if_req = 1'b0;
    go(5);

    // 5: reset mid-transaction, grant on release
    base = cyc;
    xg(1, 1'b0, 32'h50, 1'b0, 32'h0);
    xl(2, 1'b1, 1'b0); xl(3, 1'b1, 1'b0);
    xg(4, 1'b0, 32'h60, 1'b0, 32'h0);
    xr(6, 1'b0, pat(6));
    xl(5, 1'b0, 1'b1); xl(7, 1'b0, 1'b0);
    go(1); if_req = 1'b1; if_addr = 32'h50;
    go(2); reset = 1'b1; mem_req = 1'b1; mem_addr = 32'h58;
    go(4); reset = 1'b0; mem_req = 1'b0; if_addr = 32'h60;
    go(5); if_req = 1'b0;
    go(8);

    // 6: MEM_LAT=1 streaming on the second instance
    reset = 1'b1;
    step();
    reset = 1'b0; sel = 1'b1;
    step();
    base = cyc;
    for (int k = 1; k <= 4; k++) begin
      xg(k, 1'b0, 32'h300 + 32'(4 * k), 1'b0, 32'h0);
      xr(k + 1, 1'b0, pat(k + 1));
    end
    xl(1, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) xl(k, 1'b0, 1'b1);
    xl(6, 1'b0, 1'b0);
    go(1); if_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if_addr = 32'h300 + 32'(4 * k);
      go(k + 1);
    end
    if_req = 1'b0;
    go(7);
    done = 1'b1;
  end

endmodule
